// File: rtl/pc_pkg.sv
// Shared op encodings for the program-counter sequencer.
package pc_pkg;

  localparam int OP_W = 3;

  // Codes 5..7 are reserved and execute as OP_NEXT.
  typedef enum logic [OP_W-1:0] {
    OP_NEXT   = 3'd0,
    OP_BRANCH = 3'd1,
    OP_JUMP   = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the instruction stream driver and pc_sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  import pc_pkg::*;

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  // advance is a valid-only strobe: the sequencer is always ready, so every
  // cycle with advance=1 executes op exactly once at that rising edge.
  logic             advance;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic             err_clear;
  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ovf_err;
  logic             unf_err;

  modport master (
    output advance, op, target, offset, err_clear,
    input  pc, ras_count, ras_empty, ras_full, ovf_err, unf_err
  );

  modport slave (
    input  advance, op, target, offset, err_clear,
    output pc, ras_count, ras_empty, ras_full, ovf_err, unf_err
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;

  // wp is the next free slot; since DEPTH is a power of two the pointer wraps
  // naturally, which makes an overflowing push land on the oldest entry.
  assign rp       = wp - 1'b1;
  assign pop_data = mem[rp];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp <= wp + 1'b1;
      if (!full) count <= count + 1'b1;
    end else if (pop && !empty) begin
      wp    <= rp;
      count <= count - 1'b1;
    end
  end

  // Entries are unreachable while count is zero, so they carry no reset.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: pc register, next-pc mux, return stack and sticky errors.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '1,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  pc_sequencer_if.slave        bus
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] ret_addr;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf_q;
  logic             unf_q;
  logic             empty;
  logic             full;

  assign seq_pc = pc_q + STEP_W;

  always_comb begin
    pc_next = seq_pc;
    push    = 1'b0;
    pop     = 1'b0;
    unf_set = 1'b0;
    case (bus.op)
      OP_NEXT:   pc_next = seq_pc;
      OP_BRANCH: pc_next = pc_q + bus.offset;
      OP_JUMP:   pc_next = bus.target;
      OP_CALL: begin
        pc_next = bus.target;
        push    = bus.advance;
      end
      OP_RET: begin
        if (empty) begin
          pc_next = seq_pc;
          unf_set = bus.advance;
        end else begin
          pc_next = ret_addr;
          pop     = bus.advance;
        end
      end
      default:   pc_next = seq_pc;
    endcase
  end

  assign ovf_set = push && full;

  ras_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .pop_data  (ret_addr),
    .count     (bus.ras_count),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else if (bus.advance) begin
      pc_q <= pc_next;
    end
  end

  // A new error outranks a simultaneous clear; clearing ignores advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set)            ovf_q <= 1'b1;
      else if (bus.err_clear) ovf_q <= 1'b0;
      if (unf_set)            unf_q <= 1'b1;
      else if (bus.err_clear) unf_q <= 1'b0;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ovf_err   = ovf_q;
  assign bus.unf_err   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with default parameters.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr;

  pc_sequencer_if #(.WIDTH(32), .RAS_DEPTH(4)) bus ();

  pc_sequencer u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change #1 after a rising edge, outputs sampled there too
  task automatic step(input logic [2:0] op, input logic [31:0] tgt, input logic [31:0] off,
                      input logic clr);
    bus.advance   = 1'b1;
    bus.op        = op;
    bus.target    = tgt;
    bus.offset    = off;
    bus.err_clear = clr;
    @(posedge clock);
    #1;
    bus.advance   = 1'b0;
    bus.err_clear = 1'b0;
  endtask

  task automatic idle(input logic [2:0] op, input logic clr, input int cycles);
    bus.advance   = 1'b0;
    bus.op        = op;
    bus.target    = 32'h999;
    bus.err_clear = clr;
    repeat (cycles) @(posedge clock);
    #1;
    bus.err_clear = 1'b0;
  endtask

  task automatic call_tracked(input logic [31:0] tgt);
    exp_q.push_back(bus.pc + 32'd1);
    if (exp_q.size() > 4) void'(exp_q.pop_front());
    step(OP_CALL, tgt, '0, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset         = 1'b1;
    bus.advance   = 1'b0;
    bus.op        = OP_NEXT;
    bus.target    = '0;
    bus.offset    = '0;
    bus.err_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", bus.pc, 32'hFFFF_FFFF);
    check("rst_cnt", bus.ras_count, 0);
    check("rst_empty", bus.ras_empty, 1);
    check("rst_full", bus.ras_full, 0);
    check("rst_ovf", bus.ovf_err, 0);
    check("rst_unf", bus.unf_err, 0);
    reset = 1'b0;

    // sequential from reset vector
    step(OP_NEXT, '0, '0, 1'b0); check("next0", bus.pc, 32'h0);
    step(OP_NEXT, '0, '0, 1'b0); check("next1", bus.pc, 32'h1);
    step(OP_NEXT, '0, '0, 1'b0); check("next2", bus.pc, 32'h2);

    // branch backwards, then jump
    step(OP_JUMP, 32'h10, '0, 1'b0);           check("jump10", bus.pc, 32'h10);
    step(OP_BRANCH, '0, 32'hFFFF_FFF8, 1'b0);  check("branch", bus.pc, 32'h08);
    step(OP_JUMP, 32'h100, '0, 1'b0);          check("jump100", bus.pc, 32'h100);

    // nested calls
    step(OP_JUMP, 32'h20, '0, 1'b0);
    step(OP_CALL, 32'h40, '0, 1'b0);
    check("call1_pc", bus.pc, 32'h40); check("call1_cnt", bus.ras_count, 1);
    step(OP_CALL, 32'h80, '0, 1'b0);
    check("call2_pc", bus.pc, 32'h80); check("call2_cnt", bus.ras_count, 2);
    step(OP_RET, '0, '0, 1'b0);
    check("ret1_pc", bus.pc, 32'h41); check("ret1_cnt", bus.ras_count, 1);
    step(OP_RET, '0, '0, 1'b0);
    check("ret2_pc", bus.pc, 32'h21); check("ret2_cnt", bus.ras_count, 0);
    check("ret2_empty", bus.ras_empty, 1);

    // overflow: five calls into a four-deep stack
    step(OP_JUMP, 32'h200, '0, 1'b0);
    call_tracked(32'h300);
    call_tracked(32'h400);
    call_tracked(32'h500);
    check("pre_ovf", bus.ovf_err, 0);
    call_tracked(32'h600);
    check("full_flag", bus.ras_full, 1);
    check("no_ovf_at_full", bus.ovf_err, 0);
    call_tracked(32'h700);
    check("ovf_pc", bus.pc, 32'h700);
    check("ovf_err", bus.ovf_err, 1);
    check("ovf_cnt", bus.ras_count, 4);
    for (int i = 0; i < 4; i++) begin
      exp_addr = exp_q.pop_back();
      step(OP_RET, '0, '0, 1'b0);
      check($sformatf("ovf_ret%0d", i), bus.pc, exp_addr);
    end
    check("oldest_lost", bus.pc, 32'h301);
    check("drain_cnt", bus.ras_count, 0);
    check("drain_unf", bus.unf_err, 0);
    step(OP_RET, '0, '0, 1'b0);
    check("unf_pc", bus.pc, 32'h302);
    check("unf_err", bus.unf_err, 1);
    check("unf_cnt", bus.ras_count, 0);

    // hold with advance low
    step(OP_CALL, 32'h50, '0, 1'b0);
    idle(OP_CALL, 1'b0, 3);
    check("hold_pc", bus.pc, 32'h50);
    check("hold_cnt", bus.ras_count, 1);
    check("hold_ovf", bus.ovf_err, 1);

    // clear without advance, then clear racing a new underflow
    idle(OP_CALL, 1'b1, 1);
    check("clr_ovf", bus.ovf_err, 0);
    check("clr_unf", bus.unf_err, 0);
    step(OP_RET, '0, '0, 1'b0);
    check("ret_after_hold", bus.pc, 32'h303);
    step(OP_RET, '0, '0, 1'b1);
    check("race_unf", bus.unf_err, 1);
    check("race_pc", bus.pc, 32'h304);
    idle(OP_NEXT, 1'b1, 1);
    check("race_clr", bus.unf_err, 0);

    // wrap-around and reserved codes
    step(OP_JUMP, 32'hFFFF_FFFF, '0, 1'b0);
    step(OP_NEXT, '0, '0, 1'b0);             check("wrap_next", bus.pc, 32'h0);
    step(OP_JUMP, 32'hFFFF_FFFF, '0, 1'b0);
    step(OP_CALL, 32'h10, '0, 1'b0);
    step(OP_RET, '0, '0, 1'b0);              check("wrap_call", bus.pc, 32'h0);
    step(OP_CALL, 32'h20, '0, 1'b0);
    step(3'd7, 32'h80, 32'h40, 1'b0);
    check("rsvd_pc", bus.pc, 32'h21);
    check("rsvd_cnt", bus.ras_count, 1);
    step(3'd5, 32'h80, 32'h40, 1'b0);
    check("rsvd5_pc", bus.pc, 32'h22);

    // asynchronous reset between edges with a CALL pending
    bus.advance = 1'b1;
    bus.op      = OP_CALL;
    bus.target  = 32'h500;
    #3;
    reset = 1'b1;
    #1;
    check("async_pc", bus.pc, 32'hFFFF_FFFF);
    check("async_cnt", bus.ras_count, 0);
    check("async_empty", bus.ras_empty, 1);
    @(posedge clock);
    #1;
    check("held_rst_pc", bus.pc, 32'hFFFF_FFFF);
    bus.advance = 1'b0;
    reset = 1'b0;
    step(OP_NEXT, '0, '0, 1'b0);
    check("post_rst_pc", bus.pc, 32'h0);
    check("post_rst_cnt", bus.ras_count, 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: PC and address width in bits, minimum 8.
REQ-002 SHALL have parameter STEP, default 1: sequential increment added on NEXT, CALL return address and RET underflow.
REQ-003 SHALL have parameter RESET_VECTOR, default all ones: PC value after reset, so that the first NEXT yields 0.
REQ-004 SHALL have parameter RAS_DEPTH, default 4: number of return-address stack entries, a power of two from 2 to 16.
REQ-005 SHALL have port clock  in  1  single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port advance  in  1  when 1, op is executed at this edge; when 0, all state holds.
REQ-008 SHALL have port op  in  3  operation: NEXT=0, BRANCH=1, JUMP=2, CALL=3, RET=4; codes 5-7 reserved.
REQ-009 SHALL have port target  in  WIDTH  absolute destination for JUMP and CALL.
REQ-010 SHALL have port offset  in  WIDTH  two's-complement displacement for BRANCH.
REQ-011 SHALL have port err_clear  in  1  clears both sticky error flags.
REQ-012 SHALL have port pc  out  WIDTH  current program counter, driven directly from a register.
REQ-013 SHALL have port ras_count  out  clog2(RAS_DEPTH)+1  number of valid stack entries.
REQ-014 SHALL have ports ras_empty and ras_full  out  1 each  count==0 and count==RAS_DEPTH.
REQ-015 SHALL have ports ovf_err and unf_err  out  1 each  sticky stack overflow and underflow flags.

Function
REQ-016 With advance=1, pc SHALL take its new value at the same rising edge: one-cycle latency, no combinational path from inputs to pc.
REQ-017 NEXT SHALL set pc to pc+STEP; BRANCH SHALL set pc to pc+offset; JUMP SHALL set pc to target.
REQ-018 CALL SHALL push pc+STEP onto the stack and set pc to target in the same edge.
REQ-019 RET with a non-empty stack SHALL pop the top entry into pc.
REQ-020 All address arithmetic SHALL be modulo 2^WIDTH, with silent wrap-around (e.g. all ones + 1 = 0).
REQ-021 Reserved op codes SHALL behave as NEXT and SHALL NOT change stack state.
REQ-022 CALL with a full stack SHALL overwrite the oldest entry (circular), keep ras_count at RAS_DEPTH and set ovf_err.
REQ-023 RET with an empty stack SHALL set pc to pc+STEP, leave ras_count at 0 and set unf_err.
REQ-024 err_clear SHALL clear the flags at the edge; when err_clear coincides with a new error, the new error SHALL win and the flag SHALL be set.
REQ-025 err_clear SHALL act regardless of advance.
REQ-026 With advance=0, pc, the stack and ras_count SHALL hold regardless of op.

Reset
REQ-027 Asserting reset SHALL immediately, without waiting for a clock edge, force: pc=RESET_VECTOR, ras_count=0, ras_empty=1, ras_full=0, ovf_err=0, unf_err=0.
REQ-028 Stack entry contents need not be cleared by reset, because they are unreachable while ras_count=0.
REQ-029 Reset asserted mid-sequence SHALL discard any in-flight CALL/RET.
REQ-030 The first edge after reset release SHALL execute normally.

Structure
REQ-031 The op encodings and the op-code width constant SHALL live in the shared package pc_pkg.
REQ-032 The return-address stack SHALL be a sub-module named ras_stack, with push/pop/data/count ports and the circular overwrite logic.
REQ-033 pc_sequencer SHALL contain the pc register, next-pc multiplexing and the error flags.

Verification
REQ-034 Reset, then 3x NEXT with defaults -> pc = 0xFFFFFFFF, 0, 1, 2.
REQ-035 pc=0x10, BRANCH with offset=0xFFFFFFF8 -> pc=0x08; then JUMP target=0x100 -> pc=0x100.
REQ-036 Nested CALLs from pc=0x20 to 0x40, then 0x40 to 0x80, then 2x RET -> pc=0x41, then 0x21; ras_count 2 -> 1 -> 0.
REQ-037 Overflow and underflow:
- 5 CALLs with RAS_DEPTH=4 -> ovf_err=1, ras_count=4; 4 RETs return the four newest addresses.
- A 5th RET -> pc+1 and unf_err=1.
REQ-038 Hold, clear and reset:
- advance=0 with op=CALL for 3 cycles -> pc and ras_count unchanged.
- err_clear pulse -> both flags drop.
- Reset asserted between edges -> outputs change before the next edge.
REQ-039 Wrap-around: pc=0xFFFFFFFF with NEXT -> 0; CALL at pc=0xFFFFFFFF pushes 0.
